// File: rtl/gemac_pkg.sv
// rtl/gemac_pkg.sv - shared GEMAC constants, state codes and PAUSE header helper
package gemac_pkg;

    localparam int DEF_MIN_FRAME_LEN = 64;
    localparam int DEF_MAX_FRAME_LEN = 8192;

    localparam logic [7:0]  PREAMBLE_BYTE      = 8'h55;
    localparam logic [7:0]  SFD_BYTE           = 8'hD5;
    localparam logic [47:0] SGE_FLOW_CTRL_ADDR = 48'h0180C2000001;
    localparam logic [15:0] MAC_CTRL_TYPE      = 16'h8808;
    localparam logic [15:0] PAUSE_OPCODE       = 16'h0001;

    localparam logic [2:0] RX_IDLE     = 3'd0;
    localparam logic [2:0] RX_PREAMBLE = 3'd1;
    localparam logic [2:0] RX_FRAME    = 3'd2;
    localparam logic [2:0] RX_GOOD     = 3'd3;
    localparam logic [2:0] RX_ERROR    = 3'd4;
    localparam logic [2:0] RX_DROP     = 3'd5;

    // {must_match, expected byte} for a forwarded byte index of a PAUSE frame
    function automatic logic [8:0] pause_field(input int idx);
        case (idx)
            0:       return {1'b1, SGE_FLOW_CTRL_ADDR[47:40]};
            1:       return {1'b1, SGE_FLOW_CTRL_ADDR[39:32]};
            2:       return {1'b1, SGE_FLOW_CTRL_ADDR[31:24]};
            3:       return {1'b1, SGE_FLOW_CTRL_ADDR[23:16]};
            4:       return {1'b1, SGE_FLOW_CTRL_ADDR[15:8]};
            5:       return {1'b1, SGE_FLOW_CTRL_ADDR[7:0]};
            12:      return {1'b1, MAC_CTRL_TYPE[15:8]};
            13:      return {1'b1, MAC_CTRL_TYPE[7:0]};
            14:      return {1'b1, PAUSE_OPCODE[15:8]};
            15:      return {1'b1, PAUSE_OPCODE[7:0]};
            default: return 9'd0;
        endcase
    endfunction

endpackage

// File: rtl/gemac_gmii_rx_if.sv
// rtl/gemac_gmii_rx_if.sv - GMII receive pins and user-side receive stream
interface gemac_gmii_rx_if;
    logic        GMII_RX_DV;
    logic        GMII_RX_ER;
    logic [7:0]  GMII_RXD;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic        rx_error;
    logic        pause_rcvd;
    logic [15:0] pause_time_rcvd;
    logic [7:0]  debug;

    modport master (
        input  GMII_RX_DV, GMII_RX_ER, GMII_RXD,
        output rx_data, rx_valid, rx_ack, rx_error, pause_rcvd, pause_time_rcvd, debug
    );
    modport slave (
        output GMII_RX_DV, GMII_RX_ER, GMII_RXD,
        input  rx_data, rx_valid, rx_ack, rx_error, pause_rcvd, pause_time_rcvd, debug
    );
endinterface

// File: rtl/gemac_gmii_rx_crc.sv
// rtl/gemac_gmii_rx_crc.sv - Ethernet CRC-32 unit, output in wire byte order
module gemac_gmii_rx_crc (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        calc,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    logic [31:0] crc;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // reflected CRC register, reseeded whenever the receiver is idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      crc <= 32'hFFFFFFFF;
        else if (clear) crc <= 32'hFFFFFFFF;
        else if (calc)  crc <= crc_step(crc, data);
    end

    // complemented remainder, low byte first on the wire, placed in [31:24]
    assign crc_out = {~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24]};
endmodule

// File: rtl/gemac_gmii_rx.sv
// rtl/gemac_gmii_rx.sv - GMII receive MAC with FCS/length check and PAUSE detect
module gemac_gmii_rx
    import gemac_pkg::*;
#(
    parameter int MIN_FRAME_LEN = DEF_MIN_FRAME_LEN,
    parameter int MAX_FRAME_LEN = DEF_MAX_FRAME_LEN
) (
    input  logic         GMII_RX_CLK,
    input  logic         reset_n,
    output logic         rx_clk,
    gemac_gmii_rx_if.master bus
);
    localparam int CW = $clog2(MAX_FRAME_LEN) + 1;

    logic          dv_r, er_r;
    logic [7:0]    rxd_r;
    logic [2:0]    state, next;
    logic [CW-1:0] cnt, idx;
    logic [7:0]    dl [4];
    logic [31:0]   crc_out;
    logic [15:0]   pause_cand;
    logic          pause_ok, shift, fwd, len_ok, fcs_ok, good_end, bad_end;
    logic [8:0]    pf;

    assign rx_clk    = GMII_RX_CLK;
    assign bus.debug = {5'd0, state};

    // a byte enters the delay line only while the frame continues cleanly
    assign shift    = (state == RX_FRAME) && dv_r && !er_r && (cnt != CW'(MAX_FRAME_LEN));
    assign fwd      = shift && (cnt >= CW'(4));
    assign idx      = cnt - CW'(4);
    assign pf       = pause_field(int'(idx));
    assign len_ok   = cnt >= CW'(MIN_FRAME_LEN);
    assign fcs_ok   = crc_out == {dl[3], dl[2], dl[1], dl[0]};
    assign good_end = (state == RX_FRAME) && (next == RX_GOOD);
    assign bad_end  = (state == RX_FRAME) && (next == RX_ERROR);

    // single register stage on the GMII pins
    always_ff @(posedge GMII_RX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            dv_r  <= 1'b0;
            er_r  <= 1'b0;
            rxd_r <= 8'd0;
        end else begin
            dv_r  <= bus.GMII_RX_DV;
            er_r  <= bus.GMII_RX_ER;
            rxd_r <= bus.GMII_RXD;
        end
    end

    // receive state machine on registered inputs; er beats end of frame
    always_comb begin
        next = state;
        case (state)
            RX_IDLE:
                if (dv_r) next = (!er_r && rxd_r == PREAMBLE_BYTE) ? RX_PREAMBLE : RX_DROP;
            RX_PREAMBLE:
                if (!dv_r)                      next = RX_IDLE;
                else if (er_r)                  next = RX_DROP;
                else if (rxd_r == SFD_BYTE)     next = RX_FRAME;
                else if (rxd_r != PREAMBLE_BYTE) next = RX_DROP;
            RX_FRAME:
                if (er_r)                       next = RX_ERROR;
                else if (!dv_r)                 next = (len_ok && fcs_ok) ? RX_GOOD : RX_ERROR;
                else if (cnt == CW'(MAX_FRAME_LEN)) next = RX_ERROR;
            RX_GOOD:  next = RX_IDLE;
            RX_ERROR: next = dv_r ? RX_DROP : RX_IDLE;
            RX_DROP:  if (!dv_r) next = RX_IDLE;
            default:  next = RX_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge GMII_RX_CLK or negedge reset_n) begin
        if (!reset_n) state <= RX_IDLE;
        else          state <= next;
    end

    // length counter and 4-byte delay line that holds back the FCS
    always_ff @(posedge GMII_RX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            for (int i = 0; i < 4; i++) dl[i] <= 8'd0;
        end else begin
            if (state != RX_FRAME) cnt <= '0;
            else if (shift)        cnt <= cnt + CW'(1);
            if (shift) begin
                dl[3] <= dl[2];
                dl[2] <= dl[1];
                dl[1] <= dl[0];
                dl[0] <= rxd_r;
            end
        end
    end

    // user stream and end-of-frame status pulses
    always_ff @(posedge GMII_RX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            bus.rx_data  <= 8'd0;
            bus.rx_valid <= 1'b0;
            bus.rx_ack   <= 1'b0;
            bus.rx_error <= 1'b0;
        end else begin
            if (fwd) bus.rx_data <= dl[3];
            bus.rx_valid <= fwd;
            bus.rx_ack   <= good_end;
            bus.rx_error <= bad_end;
        end
    end

    // PAUSE header match on forwarded bytes; quanta only committed on a good frame
    always_ff @(posedge GMII_RX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            pause_ok            <= 1'b0;
            pause_cand          <= 16'd0;
            bus.pause_rcvd      <= 1'b0;
            bus.pause_time_rcvd <= 16'd0;
        end else begin
            if (state != RX_FRAME) begin
                pause_ok <= 1'b1;
            end else if (fwd) begin
                if (pf[8] && pf[7:0] != dl[3]) pause_ok <= 1'b0;
                if (idx == CW'(16)) pause_cand[15:8] <= dl[3];
                if (idx == CW'(17)) pause_cand[7:0]  <= dl[3];
            end
            bus.pause_rcvd <= good_end && pause_ok;
            if (good_end && pause_ok) bus.pause_time_rcvd <= pause_cand;
        end
    end

    gemac_gmii_rx_crc u_crc (
        .clk     (GMII_RX_CLK),
        .reset   (~reset_n),
        .clear   (state == RX_IDLE),
        .calc    (fwd),
        .data    (dl[3]),
        .crc_out (crc_out)
    );
endmodule
